// File: rtl/b_read_fetcher.sv
// B-operand read fetcher: drains the B address FIFO into memory read requests and streams
// the in-order responses to the array loader. Define B_FETCH_PERF_EN to add stall counters.
module b_read_fetcher #(
    parameter int BUS_WIDTH       = 256,
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] b_fifo_addr,
    input  logic                  b_fifo_empty,
    output logic                  b_fifo_pop,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic [BUS_WIDTH-1:0]  b_data_o,
    output logic                  b_data_valid,
    input  logic                  b_data_ready,
    output logic [15:0]           beats_o,
    output logic                  busy_o,
    output logic                  error_o
`ifdef B_FETCH_PERF_EN
    ,
    output logic [31:0]           stall_gnt_o,
    output logic [31:0]           stall_credit_o,
    output logic [31:0]           stall_out_o
`endif
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int UW    = CNT_W + 1;
    localparam logic [UW-1:0]    MAX_U = UW'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                  state_q;
    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [BUS_WIDTH-1:0]    data_q [MAX_OUTSTANDING];
    logic [15:0]             beats_q;
    logic                    error_q;

    logic [UW-1:0]           used;
    logic                    credit_avail;
    logic                    can_issue;
    logic                    gnt_fire;
    logic                    resp_wr;
    logic                    resp_err;
    logic                    buf_valid;
    logic                    out_pop;

    // Every credit is either a pending request, a granted request or a buffered beat,
    // so a response always has a free slot waiting for it.
    assign used         = UW'(inflight_q) + UW'(count_q) + UW'(mem_req_q);
    assign credit_avail = used < MAX_U;
    assign can_issue    = !b_fifo_empty && credit_avail;
    assign b_fifo_pop   = can_issue && ((state_q == IDLE) || mem_gnt);

    assign gnt_fire  = mem_req_q && mem_gnt;
    assign resp_wr   = mem_rvalid && (inflight_q != '0);
    assign resp_err  = mem_rvalid && (inflight_q == '0);
    assign buf_valid = (count_q != '0);
    assign out_pop   = buf_valid && b_data_ready;

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign b_data_valid = buf_valid;
    assign b_data_o     = data_q[rd_ptr_q];
    assign beats_o      = beats_q;
    assign error_o      = error_q;
    assign busy_o       = mem_req_q || (inflight_q != '0) || buf_valid;

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        if (gnt_fire && !resp_wr) begin
            inflight_d = inflight_q + ONE_C;
        end else if (!gnt_fire && resp_wr) begin
            inflight_d = inflight_q - ONE_C;
        end
        if (resp_wr && !out_pop) begin
            count_d = count_q + ONE_C;
        end else if (!resp_wr && out_pop) begin
            count_d = count_q - ONE_C;
        end
    end

    // Request is held until granted; a grant with credit left chains straight into the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (can_issue) begin
                        mem_addr_q <= b_fifo_addr;
                        mem_req_q  <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        if (can_issue) begin
                            mem_addr_q <= b_fifo_addr;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beats_q    <= '0;
            error_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            if (resp_wr) begin
                data_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= wr_ptr_q + ONE_P;
            end
            if (out_pop) begin
                rd_ptr_q <= rd_ptr_q + ONE_P;
            end
            if (start_i) begin
                beats_q <= '0;
            end else if (out_pop) begin
                beats_q <= beats_q + 16'd1;
            end
            if (start_i) begin
                error_q <= 1'b0;
            end else if (resp_err) begin
                error_q <= 1'b1;
            end
        end
    end

`ifdef B_FETCH_PERF_EN
    logic [31:0] stall_gnt_q, stall_credit_q, stall_out_q;

    assign stall_gnt_o    = stall_gnt_q;
    assign stall_credit_o = stall_credit_q;
    assign stall_out_o    = stall_out_q;

    // Saturating stall counters, cleared together with the beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_gnt_q    <= '0;
            stall_credit_q <= '0;
            stall_out_q    <= '0;
        end else if (start_i) begin
            stall_gnt_q    <= '0;
            stall_credit_q <= '0;
            stall_out_q    <= '0;
        end else begin
            if (mem_req_q && !mem_gnt && (stall_gnt_q != '1)) begin
                stall_gnt_q <= stall_gnt_q + 32'd1;
            end
            if (!b_fifo_empty && !credit_avail && (stall_credit_q != '1)) begin
                stall_credit_q <= stall_credit_q + 32'd1;
            end
            if (buf_valid && !b_data_ready && (stall_out_q != '1)) begin
                stall_out_q <= stall_out_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_b_read_fetcher.sv
// Directed bench for b_read_fetcher: a small address FIFO model feeds the DUT while memory
// grants, responses and loader readiness are driven cycle by cycle.
module tb_b_read_fetcher;

    logic         clk;
    logic         reset_n;
    logic         start_i;
    logic [15:0]  b_fifo_addr;
    logic         b_fifo_empty;
    logic         b_fifo_pop;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [255:0] mem_rdata;
    logic [255:0] b_data_o;
    logic         b_data_valid;
    logic         b_data_ready;
    logic [15:0]  beats_o;
    logic         busy_o;
    logic         error_o;

    int total = 0;
    int bad   = 0;
    int grants = 0;
    logic [15:0] addrQ [$];

    b_read_fetcher dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .b_fifo_addr  (b_fifo_addr),
        .b_fifo_empty (b_fifo_empty),
        .b_fifo_pop   (b_fifo_pop),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .b_data_o     (b_data_o),
        .b_data_valid (b_data_valid),
        .b_data_ready (b_data_ready),
        .beats_o      (beats_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] mkData(input int i);
        mkData = {8{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic refreshFifo();
        b_fifo_empty = (addrQ.size() == 0);
        if (b_fifo_empty) b_fifo_addr = 16'h0;
        else              b_fifo_addr = addrQ[0];
    endtask

    task automatic pushAddr(input logic [15:0] a);
        addrQ.push_back(a);
        refreshFifo();
    endtask

    task automatic applyStimulus(input logic gnt, input logic rvalid, input logic [255:0] rdata,
                                 input logic ready, input logic start);
        mem_gnt      = gnt;
        mem_rvalid   = rvalid;
        mem_rdata    = rdata;
        b_data_ready = ready;
        start_i      = start;
        #1;
    endtask

    // Advance one clock: the FIFO model pops on the edge the DUT pops, inputs change at negedge.
    task automatic nextCycle();
        logic popSeen;
        popSeen = b_fifo_pop;
        if (mem_req && mem_gnt) grants++;
        checkOutput("pop_empty", b_fifo_pop & b_fifo_empty, 0);
        @(posedge clk);
        if (popSeen && addrQ.size() > 0) void'(addrQ.pop_front());
        @(negedge clk);
        refreshFifo();
    endtask

    initial begin
        reset_n = 1'b0;
        refreshFifo();
        applyStimulus(0, 0, '0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_valid", b_data_valid, 0);
        checkOutput("rst_data", b_data_o, 0);
        checkOutput("rst_beats", beats_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_err", error_o, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] single beat");
        pushAddr(16'h0100);
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t1_pop", b_fifo_pop, 1);
        checkOutput("t1_req_pre", mem_req, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t1_req", mem_req, 1);
        checkOutput("t1_addr", mem_addr, 16'h0100);
        checkOutput("t1_pop2", b_fifo_pop, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t1_req_off", mem_req, 0);
        checkOutput("t1_busy", busy_o, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        nextCycle();
        applyStimulus(1, 1, mkData(1), 1, 0);
        checkOutput("t1_valid_pre", b_data_valid, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t1_valid", b_data_valid, 1);
        checkOutput("t1_data", b_data_o, mkData(1));
        checkOutput("t1_beats0", beats_o, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t1_valid_post", b_data_valid, 0);
        checkOutput("t1_beats1", beats_o, 1);
        checkOutput("t1_idle", busy_o, 0);

        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) pushAddr(16'(i * 32));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, '0, 1, 0);
            checkOutput("t2_pop", b_fifo_pop, 1);
            checkOutput("t2_req", mem_req, (i > 0));
            if (i > 0) checkOutput("t2_addr", mem_addr, 16'((i - 1) * 32));
            nextCycle();
        end
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t2_req_last", mem_req, 1);
        checkOutput("t2_addr_last", mem_addr, 16'h0060);
        checkOutput("t2_pop_last", b_fifo_pop, 0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, mkData(20 + i), 1, 0);
            checkOutput("t2_req_off", mem_req, 0);
            checkOutput("t2_valid", b_data_valid, (i > 0));
            if (i > 0) checkOutput("t2_data", b_data_o, mkData(19 + i));
            nextCycle();
        end
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t2_data_last", b_data_o, mkData(23));
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t2_valid_end", b_data_valid, 0);
        checkOutput("t2_beats", beats_o, 5);

        $display("[TB] credit stall");
        applyStimulus(1, 0, '0, 0, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t3_beats_clr", beats_o, 0);
        grants = 0;
        for (int i = 0; i < 8; i++) pushAddr(16'h1000 + 16'(i * 16));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, '0, 0, 0);
            checkOutput("t3_pop", b_fifo_pop, 1);
            nextCycle();
        end
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t3_addr4", mem_addr, 16'h1030);
        checkOutput("t3_pop_stall", b_fifo_pop, 0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, mkData(30 + i), 0, 0);
            checkOutput("t3_pop_hold", b_fifo_pop, 0);
            checkOutput("t3_req_hold", mem_req, 0);
            nextCycle();
        end
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t3_grants4", grants, 4);
        checkOutput("t3_head", b_data_o, mkData(30));
        checkOutput("t3_pop_full", b_fifo_pop, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t3_pop_credit", b_fifo_pop, 1);
        checkOutput("t3_beats1", beats_o, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t3_req5", mem_req, 1);
        checkOutput("t3_addr5", mem_addr, 16'h1040);
        checkOutput("t3_pop_again", b_fifo_pop, 0);
        nextCycle();
        addrQ.delete();
        refreshFifo();
        applyStimulus(1, 1, mkData(34), 1, 0);
        checkOutput("t3_req_off", mem_req, 0);
        checkOutput("t3_grants5", grants, 5);
        checkOutput("t3_data1", b_data_o, mkData(31));
        nextCycle();
        for (int i = 2; i < 5; i++) begin
            applyStimulus(1, 0, '0, 1, 0);
            checkOutput("t3_valid", b_data_valid, 1);
            checkOutput("t3_data", b_data_o, mkData(30 + i));
            nextCycle();
        end
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t3_valid_end", b_data_valid, 0);
        checkOutput("t3_beats", beats_o, 5);
        checkOutput("t3_idle", busy_o, 0);

        $display("[TB] grant stall");
        pushAddr(16'h2000);
        pushAddr(16'h2020);
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("t4_pop", b_fifo_pop, 1);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, '0, 1, 0);
            checkOutput("t4_req", mem_req, 1);
            checkOutput("t4_addr", mem_addr, 16'h2000);
            checkOutput("t4_pop_hold", b_fifo_pop, 0);
            nextCycle();
        end
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t4_addr_gnt", mem_addr, 16'h2000);
        checkOutput("t4_pop_gnt", b_fifo_pop, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t4_addr2", mem_addr, 16'h2020);
        checkOutput("t4_pop2", b_fifo_pop, 0);
        nextCycle();
        applyStimulus(1, 1, mkData(40), 1, 0);
        checkOutput("t4_req_off", mem_req, 0);
        nextCycle();
        applyStimulus(1, 1, mkData(41), 1, 1);
        checkOutput("t4_data0", b_data_o, mkData(40));
        checkOutput("t4_beats_pre", beats_o, 5);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t4_data1", b_data_o, mkData(41));
        checkOutput("t4_start_wins", beats_o, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t4_valid_end", b_data_valid, 0);
        checkOutput("t4_beats", beats_o, 1);

        $display("[TB] spurious response");
        applyStimulus(1, 1, mkData(50), 1, 0);
        checkOutput("t5_err_pre", error_o, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t5_err", error_o, 1);
        checkOutput("t5_no_beat", b_data_valid, 0);
        checkOutput("t5_busy", busy_o, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 1);
        checkOutput("t5_err_sticky", error_o, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t5_err_clr", error_o, 0);
        checkOutput("t5_beats_clr", beats_o, 0);

        $display("[TB] reset mid-flight");
        pushAddr(16'h3000);
        pushAddr(16'h3020);
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_pop", b_fifo_pop, 1);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_addr0", mem_addr, 16'h3000);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_addr1", mem_addr, 16'h3020);
        nextCycle();
        applyStimulus(1, 1, mkData(60), 0, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_valid", b_data_valid, 1);
        checkOutput("t6_busy", busy_o, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_req", mem_req, 0);
        checkOutput("t6_rst_addr", mem_addr, 0);
        checkOutput("t6_rst_valid", b_data_valid, 0);
        checkOutput("t6_rst_data", b_data_o, 0);
        checkOutput("t6_rst_busy", busy_o, 0);
        checkOutput("t6_rst_beats", beats_o, 0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1, 1, mkData(61), 0, 0);
        checkOutput("t6_err_pre", error_o, 0);
        nextCycle();
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_late_err", error_o, 1);
        checkOutput("t6_no_beat", b_data_valid, 0);
        checkOutput("t6_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
